prot_eng_rx_strip: RTL and testbench
====================================

Name: prot_eng_rx_strip

Overview:
- Receive-side counterpart of the TX protocol engine, which prepends a settings-register header to outgoing frames.
- Consumes a 36-bit FIFO stream {occ[1:0],eof,sof,data[31:0]}, checks one header line against a programmable value/mask, strips N header lines, and forwards the payload with a regenerated sof.
- Mismatching, short and payload-less packets are dropped whole; pass and drop counts are exported.
- Sits between the Ethernet RX realign stage and the DSP/control demux.

Parameters:
- BASE, 0, settings-bus base address; the block decodes BASE..BASE+3.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- clear  in  1  synchronous soft clear: returns FSM to IDLE and zeroes counters; settings retained
- set_stb  in  1  settings write strobe
- set_addr  in  8  settings address
- set_data  in  32  settings data
- datain  in  36  {occ,eof,sof,data}
- src_rdy_i  in  1  upstream data valid
- dst_rdy_o  out  1  block accepts datain
- dataout  out  36  {occ,eof,sof,data}
- src_rdy_o  out  1  dataout valid
- dst_rdy_i  in  1  downstream accepts
- pass_count  out  16  packets forwarded, saturating at 16'hFFFF
- drop_count  out  16  packets dropped, saturating at 16'hFFFF

Behaviour:
- Settings registers, written on the cycle set_stb=1 with matching set_addr; all reset to 0:
  - BASE+0: [3:0] hdr_len N, [7:4] match_idx M.
  - BASE+1: match_val.
  - BASE+2: match_mask.
  - BASE+3: [0] match_en.
- Shadow copies of all settings load on the accepted sof line. Writes during a packet take effect on the next packet.
- Transfer rule: a line moves when src_rdy_i && dst_rdy_o.
- States are IDLE, HDR, PASS and DROP. Line counter is 4 bits; the sof line is index 0.
- IDLE:
  - If live N==0 and datain sof=1: pass-through exactly as in PASS, and the line's sof is kept at 1. Go to PASS, or stay in IDLE if the line also has eof (pass_count+1).
  - Else dst_rdy_o=1 and src_rdy_o=0; non-sof lines are discarded silently.
  - An accepted sof line with N>0: counter=1, mismatch=check(line 0); go to HDR, or DROP-complete if N==1 (see below).
- check(line): when match_en && index==M && M<N, mismatch is set if (data & mask) != (val & mask). If M>=N, matching is disabled for the packet.
- HDR:
  - dst_rdy_o=1, src_rdy_o=0. Each accepted line is checked and increments the counter.
  - eof on any header line, including line N-1: drop_count+1, go to IDLE.
  - Accepted line N-1 without eof: go to DROP if mismatch, else PASS with first=1.
- PASS:
  - Combinational, zero latency: dataout = datain with the sof bit replaced by first; src_rdy_o=src_rdy_i; dst_rdy_o=dst_rdy_i.
  - first clears after the first transfer.
  - Transfer with eof: pass_count+1, go to IDLE. occ and eof pass unmodified.
- DROP: dst_rdy_o=1, src_rdy_o=0. An accepted eof line gives drop_count+1 and goes to IDLE; the count is incremented exactly once per packet.
- sof seen mid-packet in HDR/PASS/DROP: treated as ordinary data, no resync. Upstream guarantees framing.
- Reset/clear: state=IDLE, first=0, counter=0, mismatch=0, counters=0, src_rdy_o=0, dst_rdy_o follows the IDLE rule the next cycle.
  - reset also zeroes the settings.
  - clear asserted mid-PASS truncates the output packet without eof; downstream tolerates this only on global clear.
- Counters saturate and do not wrap. Counter update and clear in the same cycle: clear wins.
- Throughput: one line per cycle in every state; no bubbles between packets.

Test Plan:
- N=3, match disabled, 6-line packet A0B0C0D0+k*01010101 (eof occ=2) -> 3 lines out, data A3B3C3D3..A5B5C5D5, sof on first, eof occ=2 on last; pass_count=1.
- N=4, M=2, val=0000_1234, mask=0000_FFFF, line2=ABCD_1234 -> forwarded; repeat with line2=ABCD_1235 -> nothing out, drop_count=1, following good packet passes with no gap.
- N=4, 3-line packet with eof on line 2; then a 4-line packet -> both dropped, drop_count=2, src_rdy_o never high.
- N=0, 2-line packet -> output identical to input, zero latency; a single-line sof+eof packet -> forwarded, pass_count+1.
- dst_rdy_i toggling 1,0,0,1 during PASS -> no lost or duplicated lines, and dst_rdy_o mirrors dst_rdy_i.
- Write N=5 mid-packet while N=2 is active -> current packet strips 2, next strips 5. Assert reset mid-PASS -> all outputs and counters 0 the next cycle.

Source files
------------

// File: rtl/prot_eng_rx_strip_if.sv
// Line handshake for the 36-bit FIFO stream {occ,eof,sof,data}.
// master drives data/src_rdy, slave returns dst_rdy.
interface prot_eng_rx_strip_if;
  logic [35:0] data;
  logic        src_rdy;
  logic        dst_rdy;

  modport master (
    output data,
    output src_rdy,
    input  dst_rdy
  );

  modport slave (
    input  data,
    input  src_rdy,
    output dst_rdy
  );
endinterface

// File: rtl/prot_eng_rx_strip.sv
// RX protocol engine: checks one header line, strips N header lines,
// forwards payload with regenerated sof, counts passed/dropped packets.
module prot_eng_rx_strip #(
  parameter int BASE = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        set_stb,
  input  logic [7:0]  set_addr,
  input  logic [31:0] set_data,
  prot_eng_rx_strip_if.slave  rx,
  prot_eng_rx_strip_if.master tx,
  output logic [15:0] pass_count,
  output logic [15:0] drop_count
);

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    PASS,
    DROP
  } state_t;

  typedef struct packed {
    logic [3:0]  n;
    logic [3:0]  m;
    logic [31:0] val;
    logic [31:0] mask;
    logic        en;
  } cfg_t;

  localparam logic [7:0] A_LEN  = 8'(BASE);
  localparam logic [7:0] A_VAL  = 8'(BASE + 1);
  localparam logic [7:0] A_MASK = 8'(BASE + 2);
  localparam logic [7:0] A_EN   = 8'(BASE + 3);

  cfg_t        live;
  cfg_t        shad;
  state_t      state;
  logic [3:0]  cnt;
  logic        mismatch;
  logic        first;

  logic [35:0] datain;
  logic        src_rdy_i;
  logic        dst_rdy_i;
  logic [35:0] dataout;
  logic        src_rdy_o;
  logic        dst_rdy_o;

  logic        in_sof;
  logic        in_eof;
  logic        bypass;
  logic        fwd;
  logic        xfer;
  logic        hit0;
  logic        hit_n;
  logic        last_hdr;

  assign datain     = rx.data;
  assign src_rdy_i  = rx.src_rdy;
  assign dst_rdy_i  = tx.dst_rdy;
  assign rx.dst_rdy = dst_rdy_o;
  assign tx.data    = dataout;
  assign tx.src_rdy = src_rdy_o;

  assign in_sof = datain[32];
  assign in_eof = datain[33];

  // Masked compare; a match index beyond the header disables it.
  function automatic logic chk(
    input cfg_t        c,
    input logic [3:0]  idx,
    input logic [31:0] d
  );
    return c.en && (idx == c.m) && (c.m < c.n) &&
           ((d & c.mask) != (c.val & c.mask));
  endfunction

  function automatic logic [15:0] sat_inc(
    input logic [15:0] v
  );
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign xfer     = src_rdy_i && dst_rdy_o;
  assign hit0     = chk(live, 4'd0, datain[31:0]);
  assign hit_n    = mismatch | chk(shad, cnt, datain[31:0]);
  assign last_hdr = (cnt == shad.n - 4'd1);

  // Zero-latency forwarding path; header and drop lines are sunk.
  always_comb begin
    bypass    = (state == IDLE) && (live.n == 4'd0) && in_sof;
    fwd       = bypass || (state == PASS);
    dataout   = '0;
    src_rdy_o = 1'b0;
    dst_rdy_o = 1'b1;
    if (fwd) begin
      dataout   = {datain[35:33], bypass | first, datain[31:0]};
      src_rdy_o = src_rdy_i;
      dst_rdy_o = dst_rdy_i;
    end
  end

  // Live settings registers, written from the settings bus.
  always_ff @(posedge clk) begin
    if (reset) begin
      live <= '0;
    end else if (set_stb) begin
      unique case (1'b1)
        set_addr == A_LEN: begin
          live.n <= set_data[3:0];
          live.m <= set_data[7:4];
        end
        set_addr == A_VAL:  live.val  <= set_data;
        set_addr == A_MASK: live.mask <= set_data;
        set_addr == A_EN:   live.en   <= set_data[0];
        default: ;
      endcase
    end
  end

  // Per-packet snapshot of the settings, taken on the sof line.
  always_ff @(posedge clk) begin
    if (reset) begin
      shad <= '0;
    end else if (!clear && xfer && state == IDLE && in_sof) begin
      shad <= live;
    end
  end

  // Framing FSM with header counter, match flag and packet counters.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      mismatch   <= 1'b0;
      first      <= 1'b0;
      pass_count <= 16'd0;
      drop_count <= 16'd0;
    end else if (xfer) begin
      unique case (state)
        IDLE: begin
          if (in_sof) begin
            if (live.n == 4'd0) begin
              if (in_eof) begin
                pass_count <= sat_inc(pass_count);
              end else begin
                state <= PASS;
                first <= 1'b0;
              end
            end else begin
              cnt      <= 4'd1;
              mismatch <= hit0;
              if (live.n != 4'd1) begin
                state <= HDR;
              end else if (in_eof) begin
                drop_count <= sat_inc(drop_count);
              end else if (hit0) begin
                state <= DROP;
              end else begin
                state <= PASS;
                first <= 1'b1;
              end
            end
          end
        end
        HDR: begin
          cnt      <= cnt + 4'd1;
          mismatch <= hit_n;
          if (in_eof) begin
            drop_count <= sat_inc(drop_count);
            state      <= IDLE;
          end else if (last_hdr) begin
            if (hit_n) begin
              state <= DROP;
            end else begin
              state <= PASS;
              first <= 1'b1;
            end
          end
        end
        PASS: begin
          first <= 1'b0;
          if (in_eof) begin
            pass_count <= sat_inc(pass_count);
            state      <= IDLE;
          end
        end
        DROP: begin
          if (in_eof) begin
            drop_count <= sat_inc(drop_count);
            state      <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prot_eng_rx_strip.sv
// Bench for prot_eng_rx_strip: table of packets plus hand sequences,
// output lines checked against a queue filled when lines are driven.
module tb_prot_eng_rx_strip;

  logic        clk = 1'b0;
  logic        reset;
  logic        clear;
  logic        set_stb;
  logic [7:0]  set_addr;
  logic [31:0] set_data;
  logic [15:0] pass_count;
  logic [15:0] drop_count;

  prot_eng_rx_strip_if rx_if ();
  prot_eng_rx_strip_if tx_if ();

  prot_eng_rx_strip #(.BASE(0)) dut (
    .clk        (clk),
    .reset      (reset),
    .clear      (clear),
    .set_stb    (set_stb),
    .set_addr   (set_addr),
    .set_data   (set_data),
    .rx         (rx_if),
    .tx         (tx_if),
    .pass_count (pass_count),
    .drop_count (drop_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          wcfg;
    logic [3:0]  n;
    logic [3:0]  m;
    logic [31:0] val;
    logic [31:0] mask;
    bit          en;
    int          len;
    int          ovr_idx;
    logic [31:0] ovr_val;
    logic [3:0]  pat;
    bit          pass;
    int          fwd;
  } vec_t;

  localparam int NV = 13;
  localparam logic [31:0] BASE_D = 32'hA0B0C0D0;

  vec_t        vt[NV];
  logic [35:0] sb[$];
  int          checks = 0;
  int          errors = 0;
  int          exp_pass = 0;
  int          exp_drop = 0;
  int          n_out = 0;
  int          wr_at = -1;
  logic [7:0]  wr_addr = 8'd0;
  logic [31:0] wr_data = 32'd0;
  int          cyc;

  task automatic chk(input string nm, input logic [35:0] act,
                     input logic [35:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic wcfg(input logic [7:0] a, input logic [31:0] d);
    set_stb  = 1'b1;
    set_addr = a;
    set_data = d;
    @(posedge clk);
    #1;
    set_stb = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
  endtask

  task automatic send_pkt(input int len, input int n_exp,
                          input bit pass_exp, input logic [31:0] base,
                          input int ovr_idx, input logic [31:0] ovr_val,
                          input logic [3:0] pat, output int ncyc);
    logic [31:0] d;
    logic [35:0] line;
    int          k;
    bit          ok;
    k    = 0;
    ncyc = 0;
    for (int i = 0; i < len; i++) begin
      d = (i == ovr_idx) ? ovr_val : base + 32'(i) * 32'h01010101;
      line = {(i == len - 1) ? 2'd2 : 2'd0, i == len - 1, i == 0, d};
      if (pass_exp && i >= n_exp)
        sb.push_back({line[35:33], i == n_exp, d});
      rx_if.data    = line;
      rx_if.src_rdy = 1'b1;
      if (i == wr_at) begin
        set_stb  = 1'b1;
        set_addr = wr_addr;
        set_data = wr_data;
      end
      ok = 1'b0;
      for (int t = 0; t < 64 && !ok; t++) begin
        tx_if.dst_rdy = pat[k % 4];
        k++;
        @(negedge clk);
        if (pass_exp && i >= n_exp)
          chk("dst_rdy_mirror", 36'(rx_if.dst_rdy), 36'(tx_if.dst_rdy));
        ok = rx_if.dst_rdy;
        @(posedge clk);
        #1;
        set_stb = 1'b0;
        ncyc++;
      end
      if (!ok) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout line=%0d actual=stalled required=accepted", i);
        rx_if.src_rdy = 1'b0;
        tx_if.dst_rdy = 1'b1;
        return;
      end
    end
    rx_if.src_rdy = 1'b0;
    tx_if.dst_rdy = 1'b1;
  endtask

  task automatic chk_counts(input string tag);
    chk({tag, "_pass_count"}, 36'(pass_count), 36'(exp_pass));
    chk({tag, "_drop_count"}, 36'(drop_count), 36'(exp_drop));
  endtask

  // Output monitor: every transfer must match the queue head.
  initial begin
    logic [35:0] e;
    forever begin
      @(negedge clk);
      if (!reset && tx_if.src_rdy && tx_if.dst_rdy) begin
        n_out++;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output actual=%h required=none",
                   tx_if.data);
        end else begin
          e = sb.pop_front();
          chk("dataout", tx_if.data, e);
        end
      end
    end
  end

  initial begin
    reset         = 1'b1;
    clear         = 1'b0;
    set_stb       = 1'b0;
    set_addr      = 8'd0;
    set_data      = 32'd0;
    rx_if.data    = '0;
    rx_if.src_rdy = 1'b0;
    tx_if.dst_rdy = 1'b1;

    //        wcfg n m  val            mask           en len ovr ovr_val        pat     pass fwd
    vt[0]  = '{1, 3, 0, 32'h0,         32'h0,         0, 6, -1, 32'h0,         4'hF,   1, 3};
    vt[1]  = '{1, 4, 2, 32'h0000_1234, 32'h0000_FFFF, 1, 6,  2, 32'hABCD_1234, 4'hF,   1, 2};
    vt[2]  = '{0, 4, 2, 32'h0000_1234, 32'h0000_FFFF, 1, 6,  2, 32'hABCD_1235, 4'hF,   0, 0};
    vt[3]  = '{0, 4, 2, 32'h0000_1234, 32'h0000_FFFF, 1, 6,  2, 32'hABCD_1234, 4'hF,   1, 2};
    vt[4]  = '{1, 4, 0, 32'h0,         32'h0,         0, 3, -1, 32'h0,         4'hF,   0, 0};
    vt[5]  = '{0, 4, 0, 32'h0,         32'h0,         0, 4, -1, 32'h0,         4'hF,   0, 0};
    vt[6]  = '{1, 0, 0, 32'h0,         32'h0,         0, 2, -1, 32'h0,         4'hF,   1, 2};
    vt[7]  = '{0, 0, 0, 32'h0,         32'h0,         0, 1, -1, 32'h0,         4'hF,   1, 1};
    vt[8]  = '{1, 2, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 4, -1, 32'h0,         4'hF,   1, 2};
    vt[9]  = '{1, 1, 0, 32'hA000_0000, 32'hFF00_0000, 1, 3, -1, 32'h0,         4'hF,   1, 2};
    vt[10] = '{1, 1, 0, 32'hB000_0000, 32'hFF00_0000, 1, 3, -1, 32'h0,         4'hF,   0, 0};
    vt[11] = '{0, 1, 0, 32'hB000_0000, 32'hFF00_0000, 1, 1, -1, 32'h0,         4'hF,   0, 0};
    vt[12] = '{1, 2, 0, 32'h0,         32'h0,         0, 6, -1, 32'h0,         4'b1001, 1, 4};

    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    chk_counts("reset");
    chk("reset_src_rdy_o", 36'(tx_if.src_rdy), 36'd0);
    chk("reset_dst_rdy_o", 36'(rx_if.dst_rdy), 36'd1);
    chk("reset_dataout", tx_if.data, 36'd0);

    for (int v = 0; v < NV; v++) begin
      if (vt[v].wcfg) begin
        wcfg(8'd0, {24'd0, vt[v].m, vt[v].n});
        wcfg(8'd1, vt[v].val);
        wcfg(8'd2, vt[v].mask);
        wcfg(8'd3, {31'd0, vt[v].en});
      end
      n_out = 0;
      send_pkt(vt[v].len, int'(vt[v].n), vt[v].pass, BASE_D,
               vt[v].ovr_idx, vt[v].ovr_val, vt[v].pat, cyc);
      if (vt[v].pass) exp_pass++;
      else exp_drop++;
      chk_counts($sformatf("vec%0d", v));
      chk($sformatf("vec%0d_lines_out", v), 36'(n_out), 36'(vt[v].fwd));
      if (vt[v].pat == 4'hF)
        chk($sformatf("vec%0d_cycles", v), 36'(cyc), 36'(vt[v].len));
    end

    // Settings write mid-packet only affects the next packet.
    wcfg(8'd0, 32'd2);
    wcfg(8'd3, 32'd0);
    wr_at   = 2;
    wr_addr = 8'd0;
    wr_data = 32'd5;
    n_out   = 0;
    send_pkt(5, 2, 1'b1, 32'h1000_0000, -1, 32'd0, 4'hF, cyc);
    wr_at = -1;
    exp_pass++;
    chk("midwr_cur_lines", 36'(n_out), 36'd3);
    n_out = 0;
    send_pkt(7, 5, 1'b1, 32'h2000_0000, -1, 32'd0, 4'hF, cyc);
    exp_pass++;
    chk("midwr_next_lines", 36'(n_out), 36'd2);
    chk_counts("midwr");

    // Soft clear zeroes counters but keeps N=5.
    do_clear();
    exp_pass = 0;
    exp_drop = 0;
    chk_counts("clear");
    n_out = 0;
    send_pkt(6, 5, 1'b1, 32'h3000_0000, -1, 32'd0, 4'hF, cyc);
    exp_pass++;
    chk("clear_kept_n_lines", 36'(n_out), 36'd1);
    chk_counts("after_clear");

    // Reset in the middle of a forwarded packet.
    wcfg(8'd0, 32'd1);
    tx_if.dst_rdy = 1'b1;
    rx_if.data    = {2'd0, 1'b0, 1'b1, 32'h1111_2222};
    rx_if.src_rdy = 1'b1;
    @(posedge clk);
    #1;
    sb.push_back({2'd0, 1'b0, 1'b1, 32'h3333_4444});
    rx_if.data = {2'd0, 1'b0, 1'b0, 32'h3333_4444};
    @(posedge clk);
    #1;
    reset         = 1'b1;
    rx_if.src_rdy = 1'b0;
    rx_if.data    = '0;
    @(posedge clk);
    #1;
    reset    = 1'b0;
    exp_pass = 0;
    exp_drop = 0;
    chk_counts("midrst");
    chk("midrst_src_rdy_o", 36'(tx_if.src_rdy), 36'd0);
    chk("midrst_dataout", tx_if.data, 36'd0);
    chk("midrst_dst_rdy_o", 36'(rx_if.dst_rdy), 36'd1);

    // Settings were zeroed: N=0 forwards the packet unchanged.
    n_out = 0;
    send_pkt(2, 0, 1'b1, 32'h5A5A_0000, -1, 32'd0, 4'hF, cyc);
    exp_pass++;
    chk("post_rst_lines", 36'(n_out), 36'd2);
    chk_counts("post_rst");

    @(negedge clk);
    chk("scoreboard_empty", 36'(sb.size()), 36'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
